// File: rtl/seq_detector_param.sv
// seq_detector_param
// ------------------
// Parametrised serial pattern detector. Bits arrive on x and are consumed
// only on cycles where en is high. The detector tracks the match depth s:
// the length of the longest suffix of the consumed history that is also a
// proper prefix of PATTERN. PATTERN[N-1] is the first bit of the pattern.
// The next-state tables are built at elaboration from PATTERN with the
// KMP failure rule, so no pattern-specific logic is hand-written.
//
// Parameters:
//   N        pattern length, 2..16
//   PATTERN  N-bit pattern, MSB received first
//   OVERLAP  1 = overlapping matches, 0 = history cleared after a match
//   CW       match counter width, 1..32
//   SW       width of the debug state port (derived)
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   x            serial input bit
//   en           sample strobe for x
//   y            combinational (Mealy) match flag for the current cycle
//   y_q          y registered, one cycle later
//   match_count  saturating count of matches since reset
//   state        registered match depth s

module seq_detector_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1101,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CW      = 8,
    parameter int             SW      = (N > 2) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          x,
    input  logic          en,
    output logic          y,
    output logic          y_q,
    output logic [CW-1:0] match_count,
    output logic [SW-1:0] state
);

    // Reject illegal parameter combinations while elaborating.
    if (N < 2 || N > 16) begin : g_bad_n
        $error("seq_detector_param: N must be in 2..16");
    end
    if (CW < 1 || CW > 32) begin : g_bad_cw
        $error("seq_detector_param: CW must be in 1..32");
    end

    // Length of the longest suffix of w = prefix(s).b that is a pattern
    // prefix, limited to N-1 so a full match falls back to the longest
    // proper border of PATTERN. Bit j of w is PATTERN[N-1-j] for j < s
    // and b for j == s.
    function automatic int kmp_next(input int s, input logic b);
        int  best;
        int  max_k;
        int  idx;
        bit  ok;
        logic wb;
        best  = 0;
        max_k = (s + 1 < N) ? s + 1 : N - 1;
        for (int k = 1; k <= max_k; k++) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
                idx = s + 1 - k + i;
                wb  = (idx == s) ? b : PATTERN[N-1-idx];
                if (wb != PATTERN[N-1-i]) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                best = k;
            end
        end
        return best;
    endfunction

    // Packs kmp_next(s, b) for every s into one vector, SW bits per state.
    function automatic logic [N*SW-1:0] build_table(input logic b);
        logic [N*SW-1:0] tbl;
        tbl = '0;
        for (int s = 0; s < N; s++) begin
            tbl[s*SW +: SW] = SW'(kmp_next(s, b));
        end
        return tbl;
    endfunction

    localparam logic [N*SW-1:0] NEXT_ON_0 = build_table(1'b0);
    localparam logic [N*SW-1:0] NEXT_ON_1 = build_table(1'b1);
    localparam logic [SW-1:0]   LAST_S    = SW'(N - 1);

    logic [SW-1:0] state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          y_q_q, y_q_d;
    logic [SW-1:0] table_next;

    // Mealy match flag: last pattern bit arriving while s sits at N-1.
    // Reset and a low en both mask it so nothing is reported for a bit
    // that will not be consumed.
    always_comb begin
        y = 1'b0;
        if (!reset && en && (state_q == LAST_S) && (x == PATTERN[0])) begin
            y = 1'b1;
        end
    end

    // Transition lookup. Encodings above N-1 are unreachable; they are
    // steered to 0 so the part-select never leaves the table.
    always_comb begin
        table_next = '0;
        if (int'(state_q) < N) begin
            table_next = x ? NEXT_ON_1[int'(state_q)*SW +: SW]
                           : NEXT_ON_0[int'(state_q)*SW +: SW];
        end
    end

    // Next-state logic. With en low the depth and the count hold. The
    // registered flag always follows y so each match stays a single
    // one-cycle pulse on y_q as well.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        y_q_d   = y;
        if (en) begin
            if (y && !OVERLAP) begin
                state_d = '0;
            end else begin
                state_d = table_next;
            end
            if (y && !(&count_q)) begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // State registers; reset wins over en and discards the current bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
            count_q <= '0;
            y_q_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            y_q_q   <= y_q_d;
        end
    end

    assign state       = state_q;
    assign match_count = count_q;
    assign y_q         = y_q_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param
// ---------------------
// Drives five detector configurations from one shared bit stream and
// compares them against a reference model that works on the raw history
// of sampled bits: a match is "the last N bits equal PATTERN" and the
// depth is the longest tail of the history equal to a pattern prefix.
//   dut 0: 1101, overlap, CW=8
//   dut 1: 1101, no overlap, CW=8
//   dut 2: 111,  overlap, CW=2 (saturation)
//   dut 3: 111,  no overlap, CW=8
//   dut 4: 10101, overlap, CW=4

module tb_seq_detector_param;

    localparam int NDUT = 5;
    localparam int P_N   [NDUT] = '{4, 4, 3, 3, 5};
    localparam int P_PAT [NDUT] = '{13, 13, 7, 7, 21};
    localparam int P_OV  [NDUT] = '{1, 0, 1, 0, 1};
    localparam int P_CW  [NDUT] = '{8, 8, 2, 8, 4};

    typedef struct packed {
        logic [NDUT-1:0]       y;
        logic [NDUT-1:0]       yq;
        logic [NDUT-1:0][31:0] cnt;
        logic [NDUT-1:0][31:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic x = 1'b0;
    logic en = 1'b0;

    logic       y0, y1, y2, y3, y4;
    logic       yq0, yq1, yq2, yq3, yq4;
    logic [7:0] cnt0, cnt1, cnt3;
    logic [1:0] cnt2;
    logic [3:0] cnt4;
    logic [1:0] st0, st1, st2, st3;
    logic [2:0] st4;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    int hv [NDUT];
    int hl [NDUT];
    int mcnt [NDUT];

    seq_detector_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CW(8)) dut0 (
        .clk(clk), .reset(reset), .x(x), .en(en),
        .y(y0), .y_q(yq0), .match_count(cnt0), .state(st0));
    seq_detector_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CW(8)) dut1 (
        .clk(clk), .reset(reset), .x(x), .en(en),
        .y(y1), .y_q(yq1), .match_count(cnt1), .state(st1));
    seq_detector_param #(.N(3), .PATTERN(3'b111), .OVERLAP(1'b1), .CW(2)) dut2 (
        .clk(clk), .reset(reset), .x(x), .en(en),
        .y(y2), .y_q(yq2), .match_count(cnt2), .state(st2));
    seq_detector_param #(.N(3), .PATTERN(3'b111), .OVERLAP(1'b0), .CW(8)) dut3 (
        .clk(clk), .reset(reset), .x(x), .en(en),
        .y(y3), .y_q(yq3), .match_count(cnt3), .state(st3));
    seq_detector_param #(.N(5), .PATTERN(5'b10101), .OVERLAP(1'b1), .CW(4)) dut4 (
        .clk(clk), .reset(reset), .x(x), .en(en),
        .y(y4), .y_q(yq4), .match_count(cnt4), .state(st4));

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // One comparison: counts it and reports a FAIL line on disagreement.
    task automatic checkOutput(input string name, input int c,
                               input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("[TB] FAIL %s dut%0d: got %0d, expected %0d at %0t",
                     name, c, act, expv, $time);
        end
    endtask

    // Drives one cycle of inputs at the falling edge, steps the reference
    // model for every configuration and queues what the monitor should see.
    task automatic applyStimulus(input logic r, input logic e, input logic b);
        exp_t ex;
        bit   m;
        int   best;
        @(negedge clk);
        reset = r;
        en    = e;
        x     = b;
        ex    = '0;
        for (int c = 0; c < NDUT; c++) begin
            m = 1'b0;
            if (r) begin
                hv[c]   = 0;
                hl[c]   = 0;
                mcnt[c] = 0;
            end else if (e) begin
                hv[c] = ((hv[c] << 1) | int'(b)) & 32'hFFFF;
                if (hl[c] < 16) hl[c] = hl[c] + 1;
                m = (hl[c] >= P_N[c]) &&
                    ((hv[c] & ((1 << P_N[c]) - 1)) == P_PAT[c]);
                if (m) begin
                    if (mcnt[c] < (1 << P_CW[c]) - 1) mcnt[c] = mcnt[c] + 1;
                    if (P_OV[c] == 0) begin
                        hv[c] = 0;
                        hl[c] = 0;
                    end
                end
            end
            best = 0;
            for (int k = 1; k < P_N[c]; k++) begin
                if (k <= hl[c] &&
                    ((hv[c] & ((1 << k) - 1)) == (P_PAT[c] >> (P_N[c] - k))))
                    best = k;
            end
            ex.y[c]   = m;
            ex.yq[c]  = m;
            ex.cnt[c] = mcnt[c];
            ex.st[c]  = best;
        end
        sb.push_back(ex);
    endtask

    // Feeds n bits of 'bits' MSB-first with en held high.
    task automatic feedBits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b1, bits[i]);
        end
    endtask

    // Monitor: pops one expectation per driven cycle, checks the Mealy
    // flag while the bit is presented, then the registered outputs just
    // after the edge that consumes it.
    initial begin
        exp_t ex;
        int   ay [NDUT];
        int   aq [NDUT];
        int   ac [NDUT];
        int   as [NDUT];
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                ex = sb.pop_front();
                ay = '{int'(y0), int'(y1), int'(y2), int'(y3), int'(y4)};
                for (int c = 0; c < NDUT; c++)
                    checkOutput("y", c, ay[c], int'(ex.y[c]));
                @(posedge clk);
                #1;
                aq = '{int'(yq0), int'(yq1), int'(yq2), int'(yq3), int'(yq4)};
                ac = '{int'(cnt0), int'(cnt1), int'(cnt2), int'(cnt3), int'(cnt4)};
                as = '{int'(st0), int'(st1), int'(st2), int'(st3), int'(st4)};
                for (int c = 0; c < NDUT; c++) begin
                    checkOutput("y_q", c, aq[c], int'(ex.yq[c]));
                    checkOutput("match_count", c, ac[c], int'(ex.cnt[c]));
                    checkOutput("state", c, as[c], int'(ex.st[c]));
                end
            end
        end
    end

    // Directed scenarios first, then a long randomized stream.
    initial begin
        for (int c = 0; c < NDUT; c++) begin
            hv[c]   = 0;
            hl[c]   = 0;
            mcnt[c] = 0;
        end
        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);

        $display("[TB] overlap stream 1101101");
        feedBits(16'b1101101, 7);
        applyStimulus(1'b1, 1'b0, 1'b0);

        $display("[TB] failure transitions 11101");
        feedBits(16'b11101, 5);
        applyStimulus(1'b1, 1'b0, 1'b0);

        $display("[TB] five ones");
        feedBits(16'b11111, 5);
        applyStimulus(1'b1, 1'b0, 1'b0);

        $display("[TB] enable gap");
        feedBits(16'b11, 2);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        feedBits(16'b01, 2);

        $display("[TB] reset mid-sequence");
        feedBits(16'b110, 3);
        applyStimulus(1'b1, 1'b1, 1'b1);
        feedBits(16'b1, 1);

        $display("[TB] saturation");
        applyStimulus(1'b1, 1'b0, 1'b0);
        feedBits(16'b11111111, 8);

        $display("[TB] random stream");
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 99) < 2,
                          $urandom_range(0, 99) < 80,
                          1'($urandom_range(0, 1)));
        end
        applyStimulus(1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0",
                     sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
